// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Buffers fetched instructions in a DEPTH-entry FIFO and presents the oldest
// one through a registered decode stage. The decode fields are fixed slices of
// the registered word, so every field always comes from one instruction.
//
// Handshake rules:
//   - An instruction is accepted on a cycle where in_valid && in_ready.
//   - The presented instruction is consumed on a cycle where out_valid && out_ready.
//   - in_ready is derived only from the registered count and flush. It never
//     depends on out_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     fetched instruction word and its PC
//   flush               synchronous discard of everything held
//   out_valid/out_ready decode-side handshake
//   opc, rs1_rs, rs2_rd, rd, imm_j, imm_ba
//                       raw fields of the presented instruction
//   imm_ext             imm_ba, sign- or zero-extended according to IMM_SIGNED
//   out_pc              PC of the presented instruction
//   count               FIFO occupancy; the output register is not included
// -----------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 32,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               opc,
    output logic [4:0]               rs1_rs,
    output logic [4:0]               rs2_rd,
    output logic [4:0]               rd,
    output logic [25:0]              imm_j,
    output logic [15:0]              imm_ba,
    output logic [31:0]              imm_ext,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + 32;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Each FIFO entry holds {pc, instr}.
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_out_valid;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc;

    logic            w_accept;
    logic            w_consume;
    logic            w_load;
    logic            w_fifo_empty;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic [EW-1:0]   w_head;

    assign in_ready     = (r_count < DEPTH_C) && !flush;
    assign w_accept     = in_valid && in_ready;
    assign w_consume    = r_out_valid && out_ready;
    assign w_load       = !r_out_valid || w_consume;
    assign w_fifo_empty = (r_count == '0);
    // The head moves to the output register whenever that register can take a
    // new word. A flush discards the whole FIFO, so nothing is popped then.
    assign w_pop        = w_load && !w_fifo_empty && !flush;
    // Bypass is allowed only when the FIFO is empty, which keeps strict order.
    assign w_bypass     = w_accept && w_fifo_empty && w_load;
    assign w_push       = w_accept && !w_bypass;
    assign w_head       = r_mem[r_rd_ptr];

    // FIFO storage needs no reset. The pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Output register. When nothing can be loaded, the fields keep their last
    // word and only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_instr     <= '0;
            r_pc        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (!w_fifo_empty) begin
                r_out_valid <= 1'b1;
                r_instr     <= w_head[31:0];
                r_pc        <= w_head[EW-1:32];
            end else if (w_bypass) begin
                r_out_valid <= 1'b1;
                r_instr     <= in_instr;
                r_pc        <= in_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign out_pc    = r_pc;
    assign opc       = r_instr[31:26];
    assign rs1_rs    = r_instr[25:21];
    assign rs2_rd    = r_instr[20:16];
    assign rd        = r_instr[15:11];
    assign imm_j     = r_instr[25:0];
    assign imm_ba    = r_instr[15:0];
    assign imm_ext   = IMM_SIGNED ? {{16{r_instr[15]}}, r_instr[15:0]}
                                  : {16'b0, r_instr[15:0]};

endmodule

// File: tb/tb_instr_decode_queue.sv
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NV    = 22;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opc;
    logic [4:0]      rs1_rs;
    logic [4:0]      rs2_rd;
    logic [4:0]      rd;
    logic [25:0]     imm_j;
    logic [15:0]     imm_ba;
    logic [31:0]     imm_ext;
    logic [PC_W-1:0] out_pc;
    logic [CW-1:0]   count;

    // A second instance with zero extension. It gets the same inputs, and only
    // its imm_ext output is checked.
    logic            u_in_ready;
    logic            u_out_valid;
    logic [5:0]      u_opc;
    logic [4:0]      u_rs1_rs;
    logic [4:0]      u_rs2_rd;
    logic [4:0]      u_rd;
    logic [25:0]     u_imm_j;
    logic [15:0]     u_imm_ba;
    logic [31:0]     u_imm_ext;
    logic [PC_W-1:0] u_out_pc;
    logic [CW-1:0]   u_count;

    int checks   = 0;
    int failures = 0;

    instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IMM_SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .opc(opc),
        .rs1_rs(rs1_rs), .rs2_rd(rs2_rd), .rd(rd), .imm_j(imm_j),
        .imm_ba(imm_ba), .imm_ext(imm_ext), .out_pc(out_pc), .count(count)
    );

    instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IMM_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(u_out_valid), .out_ready(out_ready), .opc(u_opc),
        .rs1_rs(u_rs1_rs), .rs2_rd(u_rs2_rd), .rd(u_rd), .imm_j(u_imm_j),
        .imm_ba(u_imm_ba), .imm_ext(u_imm_ext), .out_pc(u_out_pc), .count(u_count)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic            iv;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            ordy;
        logic            fl;
        logic            e_rdy;    // in_ready before the edge
        logic            e_ov;     // out_valid after the edge
        logic [CW-1:0]   e_cnt;
        logic [PC_W-1:0] e_pc;
        logic [5:0]      e_opc;
        logic [31:0]     e_imm_s;
        logic [31:0]     e_imm_u;
    } vec_t;

    vec_t vecs [NV];

    // Scoreboard entries are {pc, instr}.
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge. Returns at the same point in
    // the next cycle.
    task automatic run_vec(input vec_t v, input int idx);
        in_valid  = v.iv;
        in_instr  = v.instr;
        in_pc     = v.pc;
        out_ready = v.ordy;
        flush     = v.fl;
        #1;
        check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_out_valid", idx), 64'(out_valid), 64'(v.e_ov));
        check($sformatf("v%0d_count", idx), 64'(count), 64'(v.e_cnt));
        check($sformatf("v%0d_out_pc", idx), 64'(out_pc), 64'(v.e_pc));
        check($sformatf("v%0d_opc", idx), 64'(opc), 64'(v.e_opc));
        check($sformatf("v%0d_imm_ext_s", idx), 64'(imm_ext), 64'(v.e_imm_s));
        check($sformatf("v%0d_imm_ext_u", idx), 64'(u_imm_ext), 64'(v.e_imm_u));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fields: iv, instr, pc, ordy, fl | e_rdy, e_ov, e_cnt, e_pc, e_opc, e_imm_s, e_imm_u
        vecs[0]  = '{1'b1, 32'h8C22_0010, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h100, 6'h23, 32'h10, 32'h10};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h100, 6'h23, 32'h10, 32'h10};
        // Six pushes while decode stalls
        vecs[2]  = '{1'b1, 32'h0400_0001, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h200, 6'h01, 32'h1, 32'h1};
        vecs[3]  = '{1'b1, 32'h0800_0002, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h200, 6'h01, 32'h1, 32'h1};
        vecs[4]  = '{1'b1, 32'h0C00_0003, 32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h200, 6'h01, 32'h1, 32'h1};
        vecs[5]  = '{1'b1, 32'h1000_0004, 32'h20C, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'h200, 6'h01, 32'h1, 32'h1};
        vecs[6]  = '{1'b1, 32'h1400_0005, 32'h210, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 32'h200, 6'h01, 32'h1, 32'h1};
        vecs[7]  = '{1'b1, 32'h1800_0006, 32'h214, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 32'h200, 6'h01, 32'h1, 32'h1};
        // The queue is full, so the consume pops the head and the 6th word is not taken yet.
        vecs[8]  = '{1'b1, 32'h1800_0006, 32'h214, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 32'h204, 6'h02, 32'h2, 32'h2};
        vecs[9]  = '{1'b1, 32'h1800_0006, 32'h214, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 32'h208, 6'h03, 32'h3, 32'h3};
        vecs[10] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h20C, 6'h04, 32'h4, 32'h4};
        vecs[11] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'h210, 6'h05, 32'h5, 32'h5};
        vecs[12] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h214, 6'h06, 32'h6, 32'h6};
        vecs[13] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h214, 6'h06, 32'h6, 32'h6};
        vecs[14] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h214, 6'h06, 32'h6, 32'h6};
        // Negative immediate
        vecs[15] = '{1'b1, 32'h2001_FFF0, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h300, 6'h08, 32'hFFFF_FFF0, 32'h0000_FFF0};
        // Three entries queued behind it, then a flush with in_valid held high
        vecs[16] = '{1'b1, 32'h1C00_0007, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h300, 6'h08, 32'hFFFF_FFF0, 32'h0000_FFF0};
        vecs[17] = '{1'b1, 32'h1C00_0008, 32'h308, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h300, 6'h08, 32'hFFFF_FFF0, 32'h0000_FFF0};
        vecs[18] = '{1'b1, 32'h1C00_0009, 32'h30C, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'h300, 6'h08, 32'hFFFF_FFF0, 32'h0000_FFF0};
        vecs[19] = '{1'b1, 32'h2400_000A, 32'h310, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h300, 6'h08, 32'hFFFF_FFF0, 32'h0000_FFF0};
        vecs[20] = '{1'b1, 32'h2800_000B, 32'h314, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h314, 6'h0A, 32'hB, 32'hB};
        vecs[21] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h314, 6'h0A, 32'hB, 32'hB};
    end

    initial begin
        logic [63:0] item;
        logic [31:0] pc_n;
        logic        acc;
        logic        cons;

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_imm_ext", 64'(imm_ext), 64'd0);
        check("rst_opc", 64'(opc), 64'd0);
        tick();

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) begin
                check("first_rs1_rs", 64'(rs1_rs), 64'd1);
                check("first_rs2_rd", 64'(rs2_rd), 64'd2);
                check("first_rd", 64'(rd), 64'd0);
                check("first_imm_ba", 64'(imm_ba), 64'h0010);
                check("first_imm_j", 64'(imm_j), 64'h022_0010);
            end
        end

        // in_valid held high while out_ready toggles, checked against a scoreboard
        pc_n = 32'h1000;
        for (int c = 0; c < 20; c++) begin
            in_valid  = 1'b1;
            in_instr  = $urandom;
            in_pc     = pc_n;
            out_ready = (c % 2 == 0);
            flush     = 1'b0;
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check("tog_unexpected_out", 64'(out_pc), 64'hFFFF_FFFF);
                end else begin
                    item = exp_q.pop_front();
                    check("tog_out_word", {32'(out_pc), opc, rs1_rs, rs2_rd, imm_ba}, item);
                end
            end
            if (acc) begin
                exp_q.push_back({pc_n, in_instr});
                pc_n = pc_n + 32'd4;
            end
            tick();
        end

        // Drain, with a bounded number of cycles
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_out", 64'(out_pc), 64'hFFFF_FFFF);
                end else begin
                    item = exp_q.pop_front();
                    check("drain_out_word", {32'(out_pc), opc, rs1_rs, rs2_rd, imm_ba}, item);
                end
            end
            tick();
        end
        check("drain_left_in_queue", 64'(exp_q.size()), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of the stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h3000_0100 + 32'(k);
            in_pc    = 32'h500 + 32'(4 * k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd2);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_pc", 64'(out_pc), 64'd0);
        check("async_rst_opc", 64'(opc), 64'd0);
        check("async_rst_imm_ba", 64'(imm_ba), 64'd0);
        check("async_rst_imm_ext", 64'(imm_ext), 64'd0);
        check("async_rst_rs", 64'({rs1_rs, rs2_rd, rd}), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Normal operation after the reset
        in_valid  = 1'b1;
        in_instr  = 32'h3C00_1234;
        in_pc     = 32'h600;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_push_valid", 64'(out_valid), 64'd1);
        check("post_rst_push_pc", 64'(out_pc), 64'h600);
        check("post_rst_push_imm", 64'(imm_ba), 64'h1234);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
